// File: rtl/flash_burst_reader_if.sv
// Bus-side request/response bundle for flash_burst_reader.
// master = bus arbiter side, slave = flash controller side.
interface flash_burst_reader_if #(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned BURST_MAX  = 8
);
  localparam int unsigned LEN_W = $clog2(BURST_MAX) + 1;

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  read_op;
  logic [LEN_W-1:0]      burst_len;
  logic                  req_ready;
  logic                  data_valid;
  logic [31:0]           bus_data_read;
  logic                  done;

  modport master (
    output bus_addr, read_op, burst_len,
    input  req_ready, data_valid, bus_data_read, done
  );

  modport slave (
    input  bus_addr, read_op, burst_len,
    output req_ready, data_valid, bus_data_read, done
  );
endinterface

// File: rtl/flash_burst_reader.sv
// Burst read controller for a x16 parallel NOR flash: two timed halfword accesses per 32-bit word.
// Optional one-word read cache enabled by defining FLASH_READ_CACHE_EN.
module flash_burst_reader #(
  parameter int unsigned ADDR_WIDTH  = 23,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned BURST_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  flash_burst_reader_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] flash_a,
  input  logic [15:0]           flash_dq,
  output logic                  flash_ce_n,
  output logic                  flash_oe_n,
  output logic                  flash_we_n,
  output logic                  flash_byte_n,
  output logic                  flash_rp_n
);
  localparam int unsigned LEN_W  = $clog2(BURST_MAX) + 1;
  localparam int unsigned WCNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_e;

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     wait_q, wait_d;
  logic [LEN_W-1:0]      words_q, words_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           lo_q, lo_d;
  logic [31:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] flash_a_q, flash_a_d;
  logic                  ce_n_q, ce_n_d;
  logic                  rp_n_q;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_W-1:0]      req_len;
  logic                  req_ready;
  logic                  word_done;
  logic                  hit;
  logic [31:0]           cache_word;

  assign req_addr  = bus.bus_addr & ~ADDR_WIDTH'(3);
  assign word_done = (state_q == ACC_HI) && (wait_q == WAIT_LAST);
  // The cycle carrying the last data_valid is already IDLE; hold off new requests until the next one.
  assign req_ready = (state_q == IDLE) && !done_q;

  always_comb begin
    if (bus.burst_len == '0)
      req_len = LEN_W'(1);
    else if (bus.burst_len > LEN_W'(BURST_MAX))
      req_len = LEN_W'(BURST_MAX);
    else
      req_len = bus.burst_len;
  end

`ifdef FLASH_READ_CACHE_EN
  logic                  cache_vld_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic [31:0]           cache_data_q;

  assign hit        = (req_len == LEN_W'(1)) && cache_vld_q && (req_addr == cache_addr_q);
  assign cache_word = cache_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else if (word_done) begin
      cache_vld_q  <= 1'b1;
      cache_addr_q <= addr_q;
      cache_data_q <= {flash_dq, lo_q};
    end
  end
`else
  assign hit        = 1'b0;
  assign cache_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    words_d = words_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.read_op && req_ready) begin
          if (hit) begin
            valid_d = 1'b1;
            done_d  = 1'b1;
            data_d  = cache_word;
          end else begin
            state_d = ACC_LO;
            addr_d  = req_addr;
            words_d = req_len;
            wait_d  = '0;
          end
        end
      end
      ACC_LO: begin
        if (wait_q == WAIT_LAST) begin
          lo_d    = flash_dq;
          wait_d  = '0;
          state_d = ACC_HI;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ACC_HI: begin
        if (word_done) begin
          data_d  = {flash_dq, lo_q};
          valid_d = 1'b1;
          wait_d  = '0;
          if (words_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            words_d = '0;
            state_d = IDLE;
          end else begin
            words_d = words_q - 1'b1;
            addr_d  = addr_q + ADDR_WIDTH'(4);
            state_d = ACC_LO;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered from the next state so they change cleanly on the clock edge.
    unique case (state_d)
      ACC_LO:  flash_a_d = addr_d;
      ACC_HI:  flash_a_d = addr_d + ADDR_WIDTH'(2);
      default: flash_a_d = flash_a_q;
    endcase
    ce_n_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    rp_n_q <= rst;
    if (!rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      flash_a_q <= '0;
      ce_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      flash_a_q <= flash_a_d;
      ce_n_q    <= ce_n_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.data_valid    = valid_q;
  assign bus.bus_data_read = data_q;
  assign bus.done          = done_q;

  assign flash_a      = flash_a_q;
  assign flash_ce_n   = ce_n_q;
  assign flash_oe_n   = ce_n_q;
  assign flash_we_n   = 1'b1;
  assign flash_byte_n = 1'b1;
  assign flash_rp_n   = rp_n_q;
endmodule

// File: tb/tb_flash_burst_reader.sv
// Self-checking bench for flash_burst_reader: per-cycle comparison against a timing/address model
// derived from the word index and phase of each cycle in a burst.
`timescale 1ns/1ps
module tb_flash_burst_reader;
  localparam int unsigned AW = 23;
  localparam int unsigned W  = 4;
  localparam int unsigned BM = 8;
  localparam int unsigned LW = $clog2(BM) + 1;
`ifdef FLASH_READ_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] flash_a;
  logic [15:0]   flash_dq;
  logic          ce_n, oe_n, we_n, byte_n, rp_n;

  int checks = 0;
  int errors = 0;

  logic [15:0]   salt = 16'h5A3C;
  logic [31:0]   held;
  bit            cvalid;
  logic [AW-1:0] caddr;
  logic [31:0]   cdata;

  flash_burst_reader_if #(.ADDR_WIDTH(AW), .BURST_MAX(BM)) bus ();

  flash_burst_reader #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .flash_a(flash_a), .flash_dq(flash_dq),
    .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n),
    .flash_byte_n(byte_n), .flash_rp_n(rp_n)
  );

  always #5 clk = ~clk;

  // Flash contents: two fixed halfwords, everything else derived from the address.
  function automatic logic [15:0] hw_model(input logic [AW-1:0] x);
    if (x == AW'(24'h000100)) return 16'h1234;
    if (x == AW'(24'h000102)) return 16'hABCD;
    return x[15:0] ^ salt;
  endfunction

  function automatic logic [31:0] word_model(input logic [AW-1:0] a);
    return {hw_model(a + AW'(2)), hw_model(a)};
  endfunction

  assign flash_dq = (!ce_n && !oe_n) ? hw_model(flash_a) : 16'hDEAD;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input bit noise, input string name);
    logic [AW-1:0] a, ea;
    logic [31:0]   expw;
    int            n, total, i, j;
    bit            hit, ev, ed, er, ece, hi;
    a     = {addr[AW-1:2], 2'b00};
    n     = (len == 0) ? 1 : ((int'(len) > BM) ? BM : int'(len));
    hit   = CACHE_EN && (n == 1) && cvalid && (a == caddr);
    total = hit ? 1 : 2 * W * n + 1;
    bus.bus_addr  = addr;
    bus.burst_len = len;
    bus.read_op   = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready at issue got %b exp 1", name, bus.req_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      bus.read_op   = (k == total + 1) ? 1'b0 : (noise ? bit'($urandom_range(0, 1)) : 1'b0);
      bus.bus_addr  = AW'($urandom);
      bus.burst_len = LW'($urandom);
      if (hit) begin
        ev   = (k == 1);
        expw = cdata;
        ece  = 1'b1;
      end else begin
        ev   = (k > 1) && (k <= total) && (((k - 1) % (2 * W)) == 0);
        j    = (k - 1) / (2 * W) - 1;
        expw = word_model(a + AW'(4 * j));
        ece  = (k >= total);
      end
      ed = (k == total);
      er = (k == total + 1);
      if (ev) begin
        held   = expw;
        cvalid = 1'b1;
        caddr  = hit ? a : a + AW'(4 * j);
        cdata  = expw;
      end
      checks++;
      if (bus.data_valid !== ev) begin
        errors++;
        $display("FAIL %s k=%0d data_valid got %b exp %b", name, k, bus.data_valid, ev);
      end
      checks++;
      if (bus.done !== ed) begin
        errors++;
        $display("FAIL %s k=%0d done got %b exp %b", name, k, bus.done, ed);
      end
      checks++;
      if (bus.req_ready !== er) begin
        errors++;
        $display("FAIL %s k=%0d req_ready got %b exp %b", name, k, bus.req_ready, er);
      end
      checks++;
      if (ce_n !== ece || oe_n !== ece) begin
        errors++;
        $display("FAIL %s k=%0d ce_n/oe_n got %b/%b exp %b", name, k, ce_n, oe_n, ece);
      end
      checks++;
      if (bus.bus_data_read !== held) begin
        errors++;
        $display("FAIL %s k=%0d bus_data_read got %h exp %h", name, k, bus.bus_data_read, held);
      end
      if (!hit && k < total) begin
        i  = (k - 1) / (2 * W);
        hi = ((k - 1) % (2 * W)) >= W;
        ea = a + AW'(4 * i + (hi ? 2 : 0));
        checks++;
        if (flash_a !== ea) begin
          errors++;
          $display("FAIL %s k=%0d flash_a got %h exp %h", name, k, flash_a, ea);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.read_op = 1'b0; bus.bus_addr = '0; bus.burst_len = '0;
    rst = 1'b0; held = '0; cvalid = 1'b0; caddr = '0; cdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.data_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset handshake got ready=%b valid=%b done=%b exp 1 0 0",
               bus.req_ready, bus.data_valid, bus.done);
    end
    checks++;
    if (bus.bus_data_read !== 32'h0 || flash_a !== '0) begin
      errors++;
      $display("FAIL reset data/addr got %h/%h exp 0/0", bus.bus_data_read, flash_a);
    end
    checks++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1 || byte_n !== 1'b1 || rp_n !== 1'b0) begin
      errors++;
      $display("FAIL reset pins got ce=%b oe=%b we=%b byte=%b rp=%b exp 1 1 1 1 0",
               ce_n, oe_n, we_n, byte_n, rp_n);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rp_n !== 1'b1 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release got rp_n=%b ready=%b exp 1 1", rp_n, bus.req_ready);
    end
  endtask

  task automatic test_single();
    do_read(AW'(24'h000101), LW'(1), 1'b0, "single");
    checks++;
    if (held !== 32'hABCD1234) begin
      errors++;
      $display("FAIL single_word model got %h exp abcd1234", held);
    end
  endtask

  task automatic test_burst4();
    do_read(AW'(24'h000200), LW'(4), 1'b0, "burst4");
  endtask

  task automatic test_wrap();
    do_read(AW'(24'h7FFFFC), LW'(2), 1'b0, "wrap");
  endtask

  task automatic test_length();
    do_read(AW'(24'h000340), LW'(0), 1'b0, "len0");
    do_read(AW'(24'h000400), LW'(15), 1'b0, "len15");
    do_read(AW'(24'h000500), LW'(3), 1'b1, "read_op_noise");
  endtask

  task automatic test_back_to_back();
    do_read(AW'(24'h000600), LW'(2), 1'b0, "b2b_first");
    do_read(AW'(24'h000610), LW'(1), 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      do_read(AW'($urandom), LW'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_reset_mid();
    bus.bus_addr = AW'(24'h000200); bus.burst_len = LW'(4); bus.read_op = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.read_op = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    held = '0; cvalid = 1'b0;
    checks++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pins got ce=%b oe=%b ready=%b exp 1 1 1", ce_n, oe_n, bus.req_ready);
    end
    checks++;
    if (bus.data_valid !== 1'b0 || bus.done !== 1'b0 || bus.bus_data_read !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid outputs got valid=%b done=%b data=%h exp 0 0 0",
               bus.data_valid, bus.done, bus.bus_data_read);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.data_valid !== 1'b0 || bus.done !== 1'b0 || ce_n !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid quiet c=%0d got valid=%b done=%b ce_n=%b exp 0 0 1",
                 c, bus.data_valid, bus.done, ce_n);
      end
    end
    do_read(AW'(24'h000100), LW'(1), 1'b0, "after_reset");
  endtask

  task automatic test_cache();
    do_read(AW'(24'h000200), LW'(1), 1'b0, "cache_prime");
    do_read(AW'(24'h000100), LW'(1), 1'b0, "cache_miss");
    do_read(AW'(24'h000100), LW'(1), 1'b0, "cache_reread");
    checks++;
    if (held !== 32'hABCD1234) begin
      errors++;
      $display("FAIL cache_reread model got %h exp abcd1234", held);
    end
    do_read(AW'(24'h000104), LW'(1), 1'b0, "cache_other");
    do_read(AW'(24'h000104), LW'(2), 1'b0, "cache_burst_same");
  endtask

  initial begin
    salt = 16'($urandom);
    test_reset();
    test_single();
    test_burst4();
    test_wrap();
    test_length();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_cache();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
